// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the main controller:
// fetch FSM states, the reset instruction word and base opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // addi x0,x0,0 - harmless word held in the instruction register after reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Combinational next-PC selection for the fetch stage.
// Priority: jalr, jal, taken branch, sequential. All sums wrap modulo 2^32.
module next_pc_gen
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        branch,
    input  logic        jump,
    input  logic        asel,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] jalr_sum;

    assign jalr_sum = rs1_data + imm;

    // pick the target; jalr clears bit 0 as the ISA requires, bit 1 may still be set
    always_comb begin
        next_pc = pc + 32'd4;
        if (jump && asel) begin
            next_pc = jalr_sum & ~32'h1;
        end else if (jump) begin
            next_pc = pc + imm;
        end else if (branch && alu_zero) begin
            next_pc = pc + imm;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/valid handshake,
// holds the instruction through execution and commits the next PC on retire.
//
// Handshake: imem_req is high for every cycle spent in FETCH; the word on
// imem_rdata is taken on the first rising edge where imem_req && imem_valid.
// imem_valid outside FETCH and retire outside EXEC are ignored.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic [31:0]  imem_rdata,
    input  logic         imem_valid,
    input  logic         branch,
    input  logic         jump,
    input  logic         asel,
    input  logic         alu_zero,
    input  logic [31:0]  imm,
    input  logic [31:0]  rs1_data,
    input  logic         retire,
    output logic [31:0]  instr,
    output logic [6:0]   opcode,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    output logic         instr_valid,
    output logic         misalign_err,
    output fetch_state_t dbg_state
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         next_misaligned;

    next_pc_gen u_next_pc_gen (
        .pc         (pc),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .branch     (branch),
        .jump       (jump),
        .asel       (asel),
        .alu_zero   (alu_zero),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    assign imem_addr = pc;
    assign opcode    = instr[6:0];
    assign pc_plus4  = pc + 32'd4;
    assign dbg_state = state;

    // fetch FSM; imem_req/instr_valid are registered alongside the state so
    // they carry no combinational path from any input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        state       <= ST_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= ST_HALT;
                        end else begin
                            pc       <= next_pc;
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= ST_HALT;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import riscv_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         imem_valid;
    logic         branch;
    logic         jump;
    logic         asel;
    logic         alu_zero;
    logic [31:0]  imm;
    logic [31:0]  rs1_data;
    logic         retire;
    logic [31:0]  instr;
    logic [6:0]   opcode;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         instr_valid;
    logic         misalign_err;
    fetch_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .branch       (branch),
        .jump         (jump),
        .asel         (asel),
        .alu_zero     (alu_zero),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .retire       (retire),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .misalign_err (misalign_err),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // architectural next-PC rule, straight from the ISA description
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic br, input logic jp,
                                             input logic as, input logic z, input logic [31:0] im,
                                             input logic [31:0] rs);
        logic [31:0] t;
        if (jp && as) begin
            t = rs + im;
            t[0] = 1'b0;
        end else if (jp) t = p + im;
        else if (br && z) t = p + im;
        else t = p + 32'd4;
        return t;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_instr"}, instr, 32'h0000_0013);
        check({tag, "_opcode"}, {25'd0, opcode}, 32'h13);
        check({tag, "_pc4"}, pc_plus4, 32'h4);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_merr"}, {31'd0, misalign_err}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    // starts in FETCH; stalls 'waits' cycles (random stray retires), then delivers word
    task automatic do_fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            retire     = 1'($urandom_range(0, 1));
            step();
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_pc", pc, m_pc);
            check("stall_instr", instr, m_instr);
            check("stall_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        retire     = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = word;
        step();
        imem_valid = 1'b0;
        m_instr = word;
        check("fetch_instr", instr, m_instr);
        check("fetch_opcode", {25'd0, opcode}, {25'd0, word[6:0]});
        check("fetch_ivalid", {31'd0, instr_valid}, 32'd1);
        check("fetch_req", {31'd0, imem_req}, 32'd0);
        check("fetch_pc", pc, m_pc);
        check("fetch_pc4", pc_plus4, m_pc + 32'd4);
    endtask

    // starts in EXEC; 'hold' cycles without retire (stray memory responses), then retire
    task automatic do_exec(input logic br, input logic jp, input logic as, input logic z,
                           input logic [31:0] im, input logic [31:0] rs, input int hold);
        logic [31:0] exp;
        for (int i = 0; i < hold; i++) begin
            retire     = 1'b0;
            imem_valid = 1'b1;
            imem_rdata = $urandom;
            jump       = 1'($urandom_range(0, 1));
            imm        = $urandom;
            step();
            check("exec_hold_instr", instr, m_instr);
            check("exec_hold_ivalid", {31'd0, instr_valid}, 32'd1);
        end
        imem_valid = 1'b0;
        branch = br; jump = jp; asel = as; alu_zero = z; imm = im; rs1_data = rs;
        retire = 1'b1;
        exp = ref_next(m_pc, br, jp, as, z, im, rs);
        step();
        retire = 1'b0;
        branch = 1'b0; jump = 1'b0; asel = 1'b0; alu_zero = 1'b0; imm = $urandom; rs1_data = $urandom;
        check("ret_ivalid", {31'd0, instr_valid}, 32'd0);
        if (exp[1:0] != 2'b00) begin
            check("ret_merr", {31'd0, misalign_err}, 32'd1);
            check("ret_halt_req", {31'd0, imem_req}, 32'd0);
            check("ret_halt_pc", pc, m_pc);
        end else begin
            m_pc = exp;
            check("ret_pc", pc, m_pc);
            check("ret_addr", imem_addr, m_pc);
            check("ret_req", {31'd0, imem_req}, 32'd1);
            check("ret_merr", {31'd0, misalign_err}, 32'd0);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_pc = 32'h0;
        m_instr = 32'h0000_0013;
        step();
        check_reset_values("rst");
        rst_n = 1'b1;
        step();
        check("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);
        check("idle_to_fetch_addr", imem_addr, 32'h0);
    endtask

    initial begin
        logic [31:0] r_imm;
        logic [31:0] r_rs1;
        rst_n = 1'b0; imem_rdata = 32'h0; imem_valid = 1'b0; branch = 1'b0; jump = 1'b0;
        asel = 1'b0; alu_zero = 1'b0; imm = 32'h0; rs1_data = 32'h0; retire = 1'b0;
        #12;
        check_reset_values("por");

        // basic fetch and sequential retire
        apply_reset();
        do_fetch(32'h0050_0093, 0);
        check("first_opcode", {25'd0, opcode}, 32'h13);
        do_exec(0, 0, 0, 0, 32'h0, 32'h0, 0);
        check("first_pc4", pc, 32'h4);

        // 3 stall cycles, then jal to 0x100
        do_fetch(32'h0FC0_006F, 3);
        do_exec(0, 1, 0, 0, 32'h0000_00FC, 32'h0, 1);
        check("jal_pc", pc, 32'h100);

        // taken branch back 8, then not-taken
        do_fetch(32'hFE00_0CE3, 0);
        do_exec(1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 0);
        check("beq_taken", pc, 32'hF8);
        do_fetch(32'h0080_006F, 1);
        do_exec(0, 1, 0, 0, 32'h8, 32'h0, 0);
        do_fetch(32'hFE00_0CE3, 0);
        do_exec(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
        check("beq_not_taken", pc, 32'h104);

        // jalr to 0x20, then jalr to 0x1004 (bit 0 cleared)
        do_fetch(32'h0000_8067, 0);
        do_exec(0, 1, 1, 0, 32'h0, 32'h20, 0);
        do_fetch(32'h0030_80E7, 0);
        check("jalr_link", pc_plus4, 32'h24);
        do_exec(0, 1, 1, 0, 32'h3, 32'h1001, 0);
        check("jalr_pc", pc, 32'h1004);

        // wrap from the top of the address space
        do_fetch(32'h0000_8067, 0);
        do_exec(0, 1, 1, 0, 32'h0, 32'hFFFF_FFFC, 0);
        do_fetch(32'h0000_0013, 0);
        check("wrap_pc4", pc_plus4, 32'h0);
        do_exec(0, 0, 0, 0, 32'h0, 32'h0, 0);
        check("wrap_pc", pc, 32'h0);

        // randomized aligned control flow
        for (int n = 0; n < 40; n++) begin
            r_imm = ($urandom_range(0, 255) * 4) - 32'd512;
            r_rs1 = {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom_range(0, 1))};
            r_rs1 = r_rs1 & 32'hFFFF_FFFD;
            do_fetch($urandom, $urandom_range(0, 2));
            do_exec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), r_imm, r_rs1, $urandom_range(0, 1));
        end

        // reset asserted mid-FETCH with a response on the bus
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        m_pc = 32'h0;
        m_instr = 32'h0000_0013;
        step();
        check("rst_hold_instr", instr, 32'h0000_0013);
        check("rst_hold_ivalid", {31'd0, instr_valid}, 32'd0);
        imem_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_req", {31'd0, imem_req}, 32'd1);

        // misaligned jalr target halts the stage
        do_fetch(32'h0000_8067, 0);
        do_exec(0, 1, 1, 0, 32'h0, 32'h20, 0);
        do_fetch(32'h0010_80E7, 0);
        do_exec(0, 1, 1, 0, 32'h1, 32'h1001, 0);
        check("halt_pc", pc, 32'h20);
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b1;
            imem_rdata = $urandom;
            retire = 1'b1;
            step();
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_ivalid", {31'd0, instr_valid}, 32'd0);
            check("halt_merr", {31'd0, misalign_err}, 32'd1);
            check("halt_pc_hold", pc, 32'h20);
            check("halt_state", {30'd0, dbg_state}, {30'd0, ST_HALT});
        end
        imem_valid = 1'b0;
        retire = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
